// File: rtl/eth_latency_measurer_tx.sv
// Purpose : builds one fixed 60-byte Ethernet/IPv4/ICMP echo frame per start pulse and streams it
//           out as 8-bit AXI-Stream; the frame layout matches the latency measurer receive path.
// Ports   : clk/rst (async active-high); mac/ip/frame_id/log_id/ping_id config sampled on start;
//           start trigger; busy, tx_count status; m_axis_* 8-bit stream master.
// Latency : first tvalid 3 cycles after the start edge (2 checksum cycles); 60 beats, no bubbles.
// Backpressure: tdata/tlast hold while tvalid && !tready; byte index advances only on handshake.
// Option  : define ETH_LATENCY_TX_CHECKSUM_EN to fill the IP and ICMP checksum bytes; otherwise
//           they are sent as zero and the adders are left out (latency is the same either way).
module eth_latency_measurer_tx #(
    parameter int C_MODE = 0   // 0: echo request (type 0x08), 1: echo reply (type 0x00)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] mac_addr_src,
    input  logic [47:0] mac_addr_dst,
    input  logic [31:0] ip_addr_src,
    input  logic [31:0] ip_addr_dst,
    input  logic [15:0] frame_id,
    input  logic [15:0] log_id,
    input  logic [15:0] ping_id,
    input  logic        start,
    output logic        busy,
    output logic [31:0] tx_count,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CSUM1 = 2'd1,
        CSUM2 = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [7:0] ICMP_TYPE = (C_MODE != 0) ? 8'h00 : 8'h08;
    localparam logic [5:0] LAST_IDX  = 6'd59;

    state_t       state_q, state_d;
    // Header bytes 0..41, byte i lives at bits [335-8i -: 8] so the concatenation reads in wire order.
    logic [335:0] hdr_q, hdr_d;
    logic [5:0]   idx_q, idx_d;
    logic [31:0]  tx_count_q, tx_count_d;
    logic [335:0] hdr_new;
    logic [335:0] hdr_shift;

    // Checksum fields are zero here; the checksum words then sum as if the field were absent.
    assign hdr_new = {mac_addr_dst, mac_addr_src, 16'h0800,
                      32'h4500_001C, frame_id, 32'h4000_4001, 16'h0000,
                      ip_addr_src, ip_addr_dst,
                      ICMP_TYPE, 8'h00, 16'h0000, log_id, ping_id};

`ifdef ETH_LATENCY_TX_CHECKSUM_EN
    logic [31:0] ip_sum_q, ip_sum_d;
    logic [31:0] icmp_sum_q, icmp_sum_d;

    // Two end-around folds always absorb every carry of a sum of at most 16 words.
    function automatic logic [15:0] fold_inv(input logic [31:0] s);
        logic [31:0] t;
        t = {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
        t = {16'h0000, t[31:16]} + {16'h0000, t[15:0]};
        return ~t[15:0];
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        idx_d      = idx_q;
        tx_count_d = tx_count_q;
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
        ip_sum_d   = ip_sum_q;
        icmp_sum_d = icmp_sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    hdr_d   = hdr_new;
                    idx_d   = 6'd0;
                    state_d = CSUM1;
                end
            end
            CSUM1: begin
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
                // IP header bytes 14..33 and ICMP bytes 34..41 (padding excluded).
                ip_sum_d = 32'(hdr_q[223:208]) + 32'(hdr_q[207:192]) + 32'(hdr_q[191:176])
                         + 32'(hdr_q[175:160]) + 32'(hdr_q[159:144]) + 32'(hdr_q[143:128])
                         + 32'(hdr_q[127:112]) + 32'(hdr_q[111:96])  + 32'(hdr_q[95:80])
                         + 32'(hdr_q[79:64]);
                icmp_sum_d = 32'(hdr_q[63:48]) + 32'(hdr_q[47:32])
                           + 32'(hdr_q[31:16]) + 32'(hdr_q[15:0]);
`endif
                state_d = CSUM2;
            end
            CSUM2: begin
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
                hdr_d[143:128] = fold_inv(ip_sum_q);    // bytes 24-25
                hdr_d[47:32]   = fold_inv(icmp_sum_q);  // bytes 36-37
`endif
                state_d = SEND;
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = 6'd0;
                        tx_count_d = tx_count_q + 32'd1;
                        state_d    = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            idx_q      <= 6'd0;
            tx_count_q <= 32'd0;
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
            ip_sum_q   <= 32'd0;
            icmp_sum_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            idx_q      <= idx_d;
            tx_count_q <= tx_count_d;
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
            ip_sum_q   <= ip_sum_d;
            icmp_sum_q <= icmp_sum_d;
`endif
        end
    end

    // Bring the current byte to the top; indices 42..59 are padding.
    assign hdr_shift = hdr_q << {idx_q, 3'b000};

    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = m_axis_tvalid && (idx_q == LAST_IDX);
        m_axis_tdata  = 8'h00;
        if (m_axis_tvalid && (idx_q < 6'd42)) begin
            m_axis_tdata = hdr_shift[335:328];
        end
    end

    assign busy     = (state_q != IDLE);
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_eth_latency_measurer_tx.sv
module tb_eth_latency_measurer_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] mac_addr_src, mac_addr_dst;
    logic [31:0] ip_addr_src, ip_addr_dst;
    logic [15:0] frame_id, log_id, ping_id;
    logic        start;
    logic        m_axis_tready;

    logic        busy, busy1;
    logic [31:0] tx_count, tx_count1;
    logic [7:0]  m_axis_tdata, tdata1;
    logic        m_axis_tlast, tlast1, m_axis_tvalid, tvalid1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] cap0 [60];
    logic [7:0] cap1 [60];
    logic [7:0] ref0 [60];
    int cap_n, tlast_bad, hold_bad, bubble_bad;

    always #5 clk = ~clk;

    eth_latency_measurer_tx #(.C_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .mac_addr_src(mac_addr_src), .mac_addr_dst(mac_addr_dst),
        .ip_addr_src(ip_addr_src), .ip_addr_dst(ip_addr_dst),
        .frame_id(frame_id), .log_id(log_id), .ping_id(ping_id),
        .start(start), .busy(busy), .tx_count(tx_count),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    eth_latency_measurer_tx #(.C_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .mac_addr_src(mac_addr_src), .mac_addr_dst(mac_addr_dst),
        .ip_addr_src(ip_addr_src), .ip_addr_dst(ip_addr_dst),
        .frame_id(frame_id), .log_id(log_id), .ping_id(ping_id),
        .start(start), .busy(busy1), .tx_count(tx_count1),
        .m_axis_tdata(tdata1), .m_axis_tlast(tlast1),
        .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-built frame for the common config; ick is the hand-computed ICMP checksum.
    function automatic logic [7:0] exp_byte(input int i, input bit mode,
                                            input logic [15:0] ping, input logic [15:0] ick);
        logic [7:0] f [42];
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h1C,
              8'h12, 8'h34, 8'h40, 8'h00, 8'h40, 8'h01,
              8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01,
              8'h0A, 8'h00, 8'h00, 8'h02, 8'h08, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        f[34] = mode ? 8'h00 : 8'h08;
        f[40] = ping[15:8];
        f[41] = ping[7:0];
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
        f[24] = 8'h14;
        f[25] = 8'hAB;
        f[36] = ick[15:8];
        f[37] = ick[7:0];
`else
        if (ick == 16'hFFFF) f[36] = 8'h00;  // ick unused in this build
`endif
        return (i < 42) ? f[i] : 8'h00;
    endfunction

    function automatic int frame_diff(input bit which, input logic [15:0] ping,
                                      input logic [15:0] ick);
        int d = 0;
        for (int i = 0; i < 60; i++) begin
            if ((which ? cap1[i] : cap0[i]) !== exp_byte(i, which, ping, ick)) d++;
        end
        return d;
    endfunction

    // Called at a negedge: pulse start, check the 3-cycle latency, return at the first valid beat.
    task automatic start_and_wait(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy1"}, 64'(busy), 64'd1);
        chk({tag, "_vld_c1"}, 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld_c2"}, 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_vld_c3"}, 64'(m_axis_tvalid), 64'd1);
    endtask

    // Collect one frame from both DUTs; returns at the negedge after the last acceptance.
    task automatic run_frame(input bit stall);
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        bit         ps = 1'b0;
        cap_n = 0; tlast_bad = 0; hold_bad = 0; bubble_bad = 0;
        for (int c = 0; c < 600; c++) begin
            if (m_axis_tvalid) begin
                if (ps && (m_axis_tdata !== pd || m_axis_tlast !== pl)) hold_bad++;
                m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_axis_tready) begin
                    if (m_axis_tlast !== (cap_n == 59)) tlast_bad++;
                    cap0[cap_n] = m_axis_tdata;
                    cap1[cap_n] = tdata1;
                    cap_n++;
                end
                ps = !m_axis_tready;
                pd = m_axis_tdata;
                pl = m_axis_tlast;
            end else if (cap_n > 0) begin
                bubble_bad++;
            end
            @(negedge clk);
            if (cap_n == 60) break;
        end
        m_axis_tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, bcnt, t0, t1;
        logic [7:0] fb40 [4];
        logic [7:0] fb41 [4];

        rst = 1'b1; start = 1'b0; m_axis_tready = 1'b1;
        mac_addr_dst = 48'h02_00_00_00_00_02;
        mac_addr_src = 48'h02_00_00_00_00_01;
        ip_addr_src  = 32'h0A00_0001;
        ip_addr_dst  = 32'h0A00_0002;
        frame_id = 16'h1234; log_id = 16'h0001; ping_id = 16'h0005;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'h00);
        chk("rst_txcnt", 64'(tx_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stall-free frame
        start_and_wait("f1");
        run_frame(1'b0);
        chk("f1_beats", 64'(cap_n), 64'd60);
        chk("f1_tlast", 64'(tlast_bad), 64'd0);
        chk("f1_bubble", 64'(bubble_bad), 64'd0);
        chk("f1_tvalid_end", 64'(m_axis_tvalid), 64'd0);
        chk("f1_busy_end", 64'(busy), 64'd0);
        chk("f1_txcnt", 64'(tx_count), 64'd1);
        chk("f1_b12_13", 64'({cap0[12], cap0[13]}), 64'h0800);
        chk("f1_b34", 64'(cap0[34]), 64'h08);
        chk("f1_b40_41", 64'({cap0[40], cap0[41]}), 64'h0005);
`ifdef ETH_LATENCY_TX_CHECKSUM_EN
        chk("f1_ipck", 64'({cap0[24], cap0[25]}), 64'h14AB);
        chk("f1_icmpck", 64'({cap0[36], cap0[37]}), 64'hF7F9);
        chk("m1_icmpck", 64'({cap1[36], cap1[37]}), 64'hFFF9);
`else
        chk("f1_ipck", 64'({cap0[24], cap0[25]}), 64'h0000);
        chk("f1_icmpck", 64'({cap0[36], cap0[37]}), 64'h0000);
        chk("m1_icmpck", 64'({cap1[36], cap1[37]}), 64'h0000);
`endif
        chk("m1_b34", 64'(cap1[34]), 64'h00);
        chk("f1_frame", 64'(frame_diff(1'b0, 16'h0005, 16'hF7F9)), 64'd0);
        chk("m1_frame", 64'(frame_diff(1'b1, 16'h0005, 16'hFFF9)), 64'd0);
        ref0 = cap0;

        // Random stalls
        start_and_wait("f2");
        run_frame(1'b1);
        chk("f2_beats", 64'(cap_n), 64'd60);
        chk("f2_hold", 64'(hold_bad), 64'd0);
        chk("f2_tlast", 64'(tlast_bad), 64'd0);
        begin
            int d = 0;
            for (int i = 0; i < 60; i++) if (cap0[i] !== ref0[i]) d++;
            chk("f2_same_bytes", 64'(d), 64'd0);
        end
        chk("f2_txcnt", 64'(tx_count), 64'd2);

        // start held for 200 cycles, ping_id changed during the first frame
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nf = 0; bcnt = 0; t0 = 0; t1 = 0;
        for (int k = 0; k < 4; k++) begin fb40[k] = 8'hXX; fb41[k] = 8'hXX; end
        start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 30) ping_id = 16'h0077;
            if (m_axis_tvalid && m_axis_tready) begin
                if (nf < 4 && bcnt == 40) fb40[nf] = m_axis_tdata;
                if (nf < 4 && bcnt == 41) fb41[nf] = m_axis_tdata;
                if (m_axis_tlast) begin
                    if (nf == 0) t0 = cyc;
                    if (nf == 1) t1 = cyc;
                    nf++;
                    bcnt = 0;
                end else begin
                    bcnt++;
                end
            end
        end
        start = 1'b0;
        chk("burst_frames", 64'(nf), 64'd3);
        chk("burst_txcnt", 64'(tx_count), 64'd3);
        chk("burst_gap", 64'(t1 - t0), 64'd63);
        chk("burst_busy", 64'(busy), 64'd1);
        chk("burst_f1_ping", 64'({fb40[0], fb41[0]}), 64'h0005);
        chk("burst_f2_ping", 64'({fb40[1], fb41[1]}), 64'h0077);
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        chk("burst_drain", 64'(busy), 64'd0);
        chk("burst_txcnt4", 64'(tx_count), 64'd4);

        // Reset in the middle of a frame
        @(negedge clk);
        start_and_wait("r");
        repeat (20) @(negedge clk);
        chk("r_beat20", 64'(m_axis_tdata), 64'h40);
        rst = 1'b1;
        #1;
        chk("r_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("r_tlast", 64'(m_axis_tlast), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_txcnt", 64'(tx_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_and_wait("f3");
        run_frame(1'b0);
        chk("f3_beats", 64'(cap_n), 64'd60);
        chk("f3_tlast", 64'(tlast_bad), 64'd0);
        chk("f3_frame", 64'(frame_diff(1'b0, 16'h0077, 16'hF787)), 64'd0);
        chk("m3_frame", 64'(frame_diff(1'b1, 16'h0077, 16'hFF87)), 64'd0);
        chk("f3_txcnt", 64'(tx_count), 64'd1);
        chk("m3_txcnt", 64'(tx_count1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eth_latency_measurer_tx.md
Name: eth_latency_measurer_tx

Overview:
- Generates one fixed-format 60-byte Ethernet/IPv4/ICMP echo frame per trigger on an 8-bit AXI-Stream master.
- Frame layout is exactly what the latency measurer receive path matches, so a frame sent by one end validates at the other.
- ICMP sequence field carries ping_id; the receive path echoes it back to software for round-trip timing.
- Sits in the core clock domain, upstream of the MAC TX FIFO.

Parameters:
C_MODE, 0, 0 = echo request (ICMP type 0x08), 1 = echo reply (ICMP type 0x00)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
mac_addr_src  in  48  source MAC
mac_addr_dst  in  48  destination MAC
ip_addr_src  in  32  source IPv4
ip_addr_dst  in  32  destination IPv4
frame_id  in  16  IPv4 identification field
log_id  in  16  ICMP identifier
ping_id  in  16  ICMP sequence number for the next frame
start  in  1  single-cycle trigger
busy  out  1  high from accepted start until last beat accepted
tx_count  out  32  frames fully sent, wraps at 2^32
m_axis_tdata  out  8  frame byte
m_axis_tlast  out  1  high on byte 59
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  sink ready

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, tvalid=0, tlast=0, tdata=0x00, tx_count=0.
- Only one clock and one reset; all config inputs are sampled in the clk domain, with no CDC.
- IDLE: start=1 latches all config inputs and ping_id into a 42-byte header register, then moves to CSUM; busy=1 from the next cycle.
- start while busy is ignored, with no queueing.
- CSUM lasts exactly 2 cycles: cycle 1 forms the 32-bit sums, cycle 2 folds the carries and inverts.
- SEND is entered on the 3rd cycle after start; tvalid=1 from that cycle.
  - First tvalid is 3 cycles after the start edge, irrespective of the optional feature.
- SEND: 6-bit byte index 0..59 advances only on tvalid&&tready.
  - tdata and tlast stay stable while tvalid&&!tready.
  - No bubbles: tvalid stays high until byte 59 is accepted.
- Byte map (big-endian fields):
  - 0-5: mac_addr_dst
  - 6-11: mac_addr_src
  - 12-13: 0x0800
  - 14-17: 0x45 00 00 1C
  - 18-19: frame_id
  - 20-23: 0x40 00 40 01
  - 24-25: IP checksum
  - 26-29: ip_addr_src
  - 30-33: ip_addr_dst
  - 34: type (C_MODE ? 0x00 : 0x08)
  - 35: 0x00
  - 36-37: ICMP checksum
  - 38-39: log_id
  - 40-41: ping_id
  - 42-59: 0x00 padding
- On acceptance of byte 59: tvalid=0, busy=0, tx_count+1 (wraps), back to IDLE.
  - A start in the same cycle as that acceptance is ignored; the next start is accepted one cycle later.
- Checksum arithmetic is 16-bit ones' complement with end-around carry, folded twice, then inverted.
  - IP checksum covers header words 14-33, with the checksum field taken as 0.
  - ICMP checksum covers bytes 34-41 only; padding is excluded.
- Config input changes after start do not affect the frame in flight.
- rst mid-frame: tvalid drops immediately and no tlast is emitted; tx_count is cleared.

Optional Feature:
- ETH_LATENCY_TX_CHECKSUM_EN defined: bytes 24-25 and 36-37 carry the computed checksums.
- Not defined: those four bytes are 0x00 and the checksum adders are omitted. The CSUM state still lasts 2 cycles, so latency is unchanged.
- Either build is accepted by the receive path, which skips those bytes.

Test Plan:
- Common config: dst 02:00:00:00:00:02, src 02:00:00:00:00:01, ip_src 0x0A000001, ip_dst 0x0A000002, frame_id 0x1234, log_id 0x0001, ping_id 0x0005, C_MODE=0, tready=1.
  - Pulse start -> first tvalid 3 cycles later; 60 beats.
  - Bytes 12-13 = 08 00; byte 34 = 0x08; bytes 40-41 = 00 05.
  - tlast only on beat 60; tx_count=1; busy low after the last beat.
- Same config with CHECKSUM_EN -> bytes 24-25 = 14 AB, bytes 36-37 = F7 F9.
  - Without the macro -> those bytes are 00.
- C_MODE=1 -> byte 34 = 0x00; with CHECKSUM_EN, bytes 36-37 = FF F9.
- Random tready stalls (about 50%) -> tdata/tlast hold while stalled; byte sequence identical to the stall-free run.
- start pulsed every cycle for 200 cycles -> exactly 3 frames sent; start on the last-beat cycle ignored; tx_count=3.
  - Changing ping_id mid-frame does not alter the current frame.
- Assert rst at beat 20 -> tvalid=0 and busy=0 the same cycle, tx_count=0; the next start produces a complete 60-byte frame.
